// File: rtl/p00_wr_framer.sv
// p00_wr_framer: frames the write-FIFO result stream into AXI4-Stream bursts.
// Beats are counted against a per-call length. tlast marks every burst end and the
// final beat. A 2-entry skid buffer fully registers the m-side outputs.
module p00_wr_framer #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  kernel_clk,
  input  logic                  kernel_rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  beats_out,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
);

  localparam int unsigned BcW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BcW-1:0] BurstMax = BcW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [BcW-1:0]        burst_q, burst_d;
  logic                  s_tready_q, s_tready_d;
  // Skid entries: head drives the m outputs, tail holds the overflow beat.
  logic                  h_valid_q, h_valid_d, t_valid_q, t_valid_d;
  logic                  h_last_q, h_last_d, t_last_q, t_last_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d, t_data_q, t_data_d;

  logic s_hs, m_hs, start_acc, in_last, out_last, push_last;

  // Handshakes and boundary decodes.
  always_comb begin
    s_hs      = s_tvalid && s_tready_q;
    m_hs      = h_valid_q && m_tready;
    start_acc = (state_q == StIdle) && start;
    in_last   = (in_cnt_q == num_q - CNT_WIDTH'(1));
    out_last  = (beats_q == num_q - CNT_WIDTH'(1));
    push_last = (burst_q == BurstMax) || in_last;
  end

  // Next-state logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_beats == '0) ? StFin : StRun;
      StRun:   if (s_hs && in_last) state_d = StDrain;
      StDrain: if (m_hs && out_last) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beat, burst and output counters; all restart on an accepted start.
  always_comb begin
    num_d    = num_q;
    in_cnt_d = in_cnt_q;
    burst_d  = burst_q;
    beats_d  = beats_q;
    if (start_acc) begin
      num_d    = num_beats;
      in_cnt_d = '0;
      burst_d  = '0;
      beats_d  = '0;
    end else begin
      if (s_hs) begin
        in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
        burst_d  = (burst_q == BurstMax) ? '0 : burst_q + BcW'(1);
      end
      if (m_hs) beats_d = beats_q + CNT_WIDTH'(1);
    end
  end

  // Skid buffer push/pop; s_tready is only raised when the buffer cannot overflow.
  always_comb begin
    h_valid_d = h_valid_q;
    h_last_d  = h_last_q;
    h_data_d  = h_data_q;
    t_valid_d = t_valid_q;
    t_last_d  = t_last_q;
    t_data_d  = t_data_q;
    if (m_hs) begin
      if (t_valid_q) begin
        h_data_d  = t_data_q;
        h_last_d  = t_last_q;
        t_valid_d = s_hs;
        t_data_d  = s_hs ? s_tdata : t_data_q;
        t_last_d  = s_hs && push_last;
      end else begin
        h_valid_d = s_hs;
        h_data_d  = s_hs ? s_tdata : h_data_q;
        h_last_d  = s_hs && push_last;
      end
    end else if (s_hs) begin
      if (!h_valid_q) begin
        h_valid_d = 1'b1;
        h_data_d  = s_tdata;
        h_last_d  = push_last;
      end else begin
        t_valid_d = 1'b1;
        t_data_d  = s_tdata;
        t_last_d  = push_last;
      end
    end
    // Tail can only be valid when head is, so tail valid means full.
    s_tready_d = (state_d == StRun) && !t_valid_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      state_q    <= StIdle;
      num_q      <= '0;
      in_cnt_q   <= '0;
      beats_q    <= '0;
      burst_q    <= '0;
      s_tready_q <= 1'b0;
      h_valid_q  <= 1'b0;
      h_last_q   <= 1'b0;
      h_data_q   <= '0;
      t_valid_q  <= 1'b0;
      t_last_q   <= 1'b0;
      t_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      in_cnt_q   <= in_cnt_d;
      beats_q    <= beats_d;
      burst_q    <= burst_d;
      s_tready_q <= s_tready_d;
      h_valid_q  <= h_valid_d;
      h_last_q   <= h_last_d;
      h_data_q   <= h_data_d;
      t_valid_q  <= t_valid_d;
      t_last_q   <= t_last_d;
      t_data_q   <= t_data_d;
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StFin);
    beats_out = beats_q;
    s_tready  = s_tready_q;
    m_tvalid  = h_valid_q;
    m_tdata   = h_data_q;
    m_tlast   = h_last_q;
  end

endmodule

// File: tb/tb_p00_wr_framer.sv
// Directed bench for p00_wr_framer: transfer table, cycle-exact short transfer,
// zero-length and ignored start, and asynchronous reset mid-transfer.
module tb_p00_wr_framer;

  localparam int unsigned DW = 512;
  localparam int unsigned BL = 64;
  localparam int unsigned CW = 32;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_beats = '0;
  logic          busy, done, s_tready, m_tvalid, m_tlast;
  logic [CW-1:0] beats_out;
  logic          s_tvalid = 1'b0;
  logic          m_tready = 1'b1;
  logic [DW-1:0] s_tdata, m_tdata;

  p00_wr_framer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .kernel_clk   (kernel_clk),
    .kernel_rst_n (kernel_rst_n),
    .start        (start),
    .num_beats    (num_beats),
    .busy         (busy),
    .done         (done),
    .beats_out    (beats_out),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast)
  );

  always #5 kernel_clk = ~kernel_clk;

  typedef struct {
    int unsigned n;
    bit          stall;
    int unsigned tl;
  } vec_t;

  typedef struct {
    logic        mv, ml, dn, by, sr;
    int unsigned bo;
  } cyc_t;

  int n_vec = 0;
  int n_err = 0;
  int unsigned s_idx = 0, m_idx = 0, s_base = 0, m_base = 0;
  int unsigned cur_n = 0, tl_cnt = 0, done_cnt = 0;
  bit stall_mode = 1'b0;

  function automatic logic [DW-1:0] pat(input int unsigned i);
    return {16{i}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: handshakes seen before the edge are scored after it.
  task automatic tick();
    bit            s_pre, m_pre, hold, exp_l;
    logic [DW-1:0] d_pre, exp_d;
    logic          l_pre;
    int unsigned   rel, occ, s_in;
    s_pre = s_tvalid && s_tready;
    m_pre = m_tvalid && m_tready;
    hold  = m_tvalid && !m_tready;
    d_pre = m_tdata;
    l_pre = m_tlast;
    @(posedge kernel_clk);
    #1;
    if (s_pre) s_idx++;
    s_tdata = pat(s_idx);
    if (m_pre) begin
      rel   = m_idx - m_base;
      exp_d = pat(m_idx);
      exp_l = ((rel % BL) == BL - 1) || (rel == cur_n - 1);
      chk("tdata_lo", d_pre[63:0], exp_d[63:0]);
      chk("tdata_hi", d_pre[DW-1:DW-64], exp_d[DW-1:DW-64]);
      chk("tlast", 64'(l_pre), 64'(exp_l));
      if (l_pre) tl_cnt++;
      m_idx++;
    end
    if (hold && kernel_rst_n) begin
      chk("hold_valid", 64'(m_tvalid), 64'(1));
      chk("hold_data", m_tdata[63:0], d_pre[63:0]);
      chk("hold_last", 64'(m_tlast), 64'(l_pre));
    end
    s_in = s_idx - s_base;
    occ  = s_in - (m_idx - m_base);
    chk("s_tready", 64'(s_tready), 64'(busy && (s_in < cur_n) && (occ < 2)));
    if (done) done_cnt++;
    if (stall_mode) begin
      m_tready = 1'($urandom_range(1, 0));
      s_tvalid = ($urandom_range(3, 0) != 0);
    end
  endtask

  task automatic do_start(input int unsigned n);
    start     = 1'b1;
    num_beats = n;
    cur_n     = n;
    s_base    = s_idx;
    m_base    = m_idx;
    tl_cnt    = 0;
    done_cnt  = 0;
    tick();
    start     = 1'b0;
    num_beats = $urandom;
  endtask

  task automatic run_xfer(input int unsigned n, input bit stall, input int unsigned exp_tl);
    stall_mode = stall;
    s_tvalid   = 1'b1;
    m_tready   = 1'b1;
    do_start(n);
    for (int c = 0; c < 6 * n + 40 && done_cnt == 0; c++) tick();
    chk("done_seen", 64'(done_cnt), 64'(1));
    chk("m_beats", 64'(m_idx - m_base), 64'(n));
    chk("s_beats", 64'(s_idx - s_base), 64'(n));
    chk("tlast_count", 64'(tl_cnt), 64'(exp_tl));
    chk("beats_out", 64'(beats_out), 64'(n));
    chk("busy_at_done", 64'(busy), 64'(0));
    stall_mode = 1'b0;
    s_tvalid   = 1'b1;
    m_tready   = 1'b1;
    tick();
    tick();
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("beats_hold", 64'(beats_out), 64'(n));
    chk("no_extra_s", 64'(s_idx - s_base), 64'(n));
  endtask

  initial begin
    vec_t vecs[8];
    cyc_t t1[6];
    vecs = '{'{4, 1'b0, 1}, '{130, 1'b0, 3}, '{64, 1'b0, 1}, '{65, 1'b0, 2},
             '{1, 1'b0, 1}, '{130, 1'b1, 3}, '{20, 1'b1, 1}, '{128, 1'b1, 2}};
    // Per cycle after the start edge: m_tvalid, m_tlast, done, busy, s_tready, beats_out.
    t1 = '{'{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0}, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1},
           '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2}, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3},
           '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4}};
    s_tdata = pat(0);

    // Reset state.
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_beats_out", 64'(beats_out), 64'(0));
    tick();
    tick();
    kernel_rst_n = 1'b1;
    tick();

    // Cycle-exact short transfer at full rate.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    do_start(4);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t1_mvalid_%0d", k), 64'(m_tvalid), 64'(t1[k].mv));
      chk($sformatf("t1_mlast_%0d", k), 64'(m_tlast), 64'(t1[k].ml));
      chk($sformatf("t1_done_%0d", k), 64'(done), 64'(t1[k].dn));
      chk($sformatf("t1_busy_%0d", k), 64'(busy), 64'(t1[k].by));
      chk($sformatf("t1_sready_%0d", k), 64'(s_tready), 64'(t1[k].sr));
      chk($sformatf("t1_beats_%0d", k), 64'(beats_out), 64'(t1[k].bo));
    end
    chk("t1_s_beats", 64'(s_idx - s_base), 64'(4));

    // Transfer table.
    for (int v = 0; v < 8; v++) run_xfer(vecs[v].n, vecs[v].stall, vecs[v].tl);

    // Zero-length transfer: straight to done, never busy, no data.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    do_start(0);
    chk("z_done", 64'(done), 64'(1));
    chk("z_busy", 64'(busy), 64'(0));
    chk("z_mvalid", 64'(m_tvalid), 64'(0));
    tick();
    chk("z_done_drop", 64'(done), 64'(0));
    chk("z_busy2", 64'(busy), 64'(0));
    chk("z_no_beats", 64'(m_idx - m_base), 64'(0));

    // Start during RUN is ignored; skid fills while the master stalls.
    m_tready = 1'b0;
    do_start(10);
    for (int k = 0; k < 4; k++) tick();
    chk("ign_full_stall", 64'(s_tready), 64'(0));
    start     = 1'b1;
    num_beats = 3;
    tick();
    start    = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
    chk("ign_done", 64'(done_cnt), 64'(1));
    chk("ign_m_beats", 64'(m_idx - m_base), 64'(10));
    chk("ign_beats_out", 64'(beats_out), 64'(10));
    chk("ign_tlast", 64'(tl_cnt), 64'(1));
    tick();

    // Asynchronous reset at beat 40 of 100.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    do_start(100);
    for (int c = 0; c < 200 && (m_idx - m_base) < 40; c++) tick();
    chk("r_reached_40", 64'(m_idx - m_base), 64'(40));
    #2;
    kernel_rst_n = 1'b0;
    #1;
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_done", 64'(done), 64'(0));
    chk("r_s_tready", 64'(s_tready), 64'(0));
    chk("r_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("r_m_tlast", 64'(m_tlast), 64'(0));
    chk("r_beats_out", 64'(beats_out), 64'(0));
    s_base   = s_idx;
    m_idx    = s_idx;
    m_base   = m_idx;
    cur_n    = 0;
    done_cnt = 0;
    tick();
    tick();
    chk("r_no_done", 64'(done_cnt), 64'(0));
    kernel_rst_n = 1'b1;
    tick();
    run_xfer(3, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
